pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed IF/ID latch. It carries an arbitrary-width payload, such as {pc, instr, pcadd4}, between two pipeline stages using a valid/ready handshake. A two-entry skid buffer keeps `in_ready` registered, so there is no combinational ready path. Stall and flush are supported with selectable priority, and the block keeps a saturating bubble counter for CPI analysis.

---
 rtl/pipe_stage_skid.sv | 115 +++++++++++
 tb/tb_pipe_stage_skid.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Purpose: parametrised pipeline stage register with a two-entry skid buffer, stall/flush and a bubble counter.
// Latency: one cycle from accept to out_valid/out_data; one payload per cycle sustained.
// Backpressure: in_ready is registered and drops only once the skid entry holds a payload.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH       = 96,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
  parameter bit               FLUSH_PRIO  = 1'b1,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] bubble_cnt
);

  // EMPTY: nothing held; ONE: main holds the head payload; TWO: skid holds the next one.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_dat;
  logic [WIDTH-1:0] skid_dat;

  logic in_fire;
  logic out_fire;
  logic eflush;

  // stall only gates the downstream transfer; upstream may still fill the skid entry.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~stall;
  // With FLUSH_PRIO = 0 a flush arriving under stall is ignored outright, not deferred.
  assign eflush   = flush & (FLUSH_PRIO ? 1'b1 : ~stall);

  // main always presents CLEAR_VALUE when empty, so it drives the output directly.
  assign out_data = main_dat;

  // Stage FSM: state, payload storage and the registered valid/ready outputs move together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      main_dat  <= CLEAR_VALUE;
      skid_dat  <= CLEAR_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (eflush) begin
      // Drop everything, including a payload offered this cycle; a concurrent
      // out_fire has already been taken by downstream.
      state     <= ST_EMPTY;
      main_dat  <= CLEAR_VALUE;
      skid_dat  <= CLEAR_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state     <= ST_ONE;
            main_dat  <= in_data;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            // Pass-through: head leaves as the new payload lands, no bubble.
            main_dat <= in_data;
          end else if (out_fire) begin
            state     <= ST_EMPTY;
            main_dat  <= CLEAR_VALUE;
            out_valid <= 1'b0;
          end else if (in_fire) begin
            state    <= ST_TWO;
            skid_dat <= in_data;
            in_ready <= 1'b0;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state    <= ST_ONE;
            main_dat <= skid_dat;
            skid_dat <= CLEAR_VALUE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          main_dat  <= CLEAR_VALUE;
          skid_dat  <= CLEAR_VALUE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles with no valid output; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int unsigned W   = 16;
  localparam logic [W-1:0] CLR = 16'hC1EA;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         stall;
  logic         flush;

  logic         a_in_ready, a_out_valid;
  logic [W-1:0] a_out_data;
  logic [15:0]  a_bubble;
  logic         b_in_ready, b_out_valid;
  logic [W-1:0] b_out_data;
  logic [15:0]  b_bubble;
  logic         c_in_ready, c_out_valid;
  logic [W-1:0] c_out_data;
  logic [3:0]   c_bubble;

  int checks   = 0;
  int failures = 0;

  // a: flush beats stall; b: stall beats flush; c: narrow counter.
  pipe_stage_skid #(.WIDTH(W), .CLEAR_VALUE(CLR), .FLUSH_PRIO(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready), .stall(stall),
    .flush(flush), .bubble_cnt(a_bubble));

  pipe_stage_skid #(.WIDTH(W), .CLEAR_VALUE(CLR), .FLUSH_PRIO(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready), .stall(stall),
    .flush(flush), .bubble_cnt(b_bubble));

  pipe_stage_skid #(.WIDTH(W), .CLEAR_VALUE(16'h0000), .FLUSH_PRIO(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(out_ready), .stall(stall),
    .flush(flush), .bubble_cnt(c_bubble));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         st;
    logic         fl;
    logic         eov;
    logic [W-1:0] eod;
    logic         eir;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic st, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  function automatic vec_t mk(input logic iv, input logic [W-1:0] d, input logic ordy,
                              input logic st, input logic fl, input logic eov,
                              input logic [W-1:0] eod, input logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.st = st; v.fl = fl;
    v.eov = eov; v.eod = eod; v.eir = eir;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int bub;
    logic prev_ov;

    // Stream 1..5
    tbl[0]  = mk(1, 16'h0001, 1, 0, 0, 1, 16'h0001, 1);
    tbl[1]  = mk(1, 16'h0002, 1, 0, 0, 1, 16'h0002, 1);
    tbl[2]  = mk(1, 16'h0003, 1, 0, 0, 1, 16'h0003, 1);
    tbl[3]  = mk(1, 16'h0004, 1, 0, 0, 1, 16'h0004, 1);
    tbl[4]  = mk(1, 16'h0005, 1, 0, 0, 1, 16'h0005, 1);
    tbl[5]  = mk(0, 16'h0000, 1, 0, 0, 0, CLR,      1);
    // Backpressure with A, B, C
    tbl[6]  = mk(1, 16'h000A, 0, 0, 0, 1, 16'h000A, 1);
    tbl[7]  = mk(1, 16'h000B, 0, 0, 0, 1, 16'h000A, 0);
    tbl[8]  = mk(1, 16'h000C, 0, 0, 0, 1, 16'h000A, 0);
    tbl[9]  = mk(1, 16'h000C, 1, 0, 0, 1, 16'h000B, 1);
    tbl[10] = mk(1, 16'h000C, 1, 0, 0, 1, 16'h000C, 1);
    tbl[11] = mk(0, 16'h0000, 1, 0, 0, 0, CLR,      1);
    // Flush in TWO under stall, offered input dropped
    tbl[12] = mk(1, 16'h0011, 0, 0, 0, 1, 16'h0011, 1);
    tbl[13] = mk(1, 16'h0022, 0, 0, 0, 1, 16'h0011, 0);
    tbl[14] = mk(1, 16'h0033, 1, 1, 1, 0, CLR,      1);
    tbl[15] = mk(0, 16'h0000, 1, 0, 0, 0, CLR,      1);
    tbl[16] = mk(1, 16'h0044, 1, 0, 0, 1, 16'h0044, 1);
    tbl[17] = mk(0, 16'h0000, 1, 0, 0, 0, CLR,      1);
    // Stall still lets the skid fill
    tbl[18] = mk(1, 16'h0055, 1, 1, 0, 1, 16'h0055, 1);
    tbl[19] = mk(1, 16'h0066, 1, 1, 0, 1, 16'h0055, 0);
    tbl[20] = mk(0, 16'h0000, 1, 0, 0, 1, 16'h0066, 1);
    tbl[21] = mk(0, 16'h0000, 1, 0, 0, 0, CLR,      1);
    // Flush in ONE with concurrent in_fire
    tbl[22] = mk(1, 16'h0077, 1, 0, 0, 1, 16'h0077, 1);
    tbl[23] = mk(1, 16'h0088, 1, 0, 1, 0, CLR,      1);
    tbl[24] = mk(0, 16'h0000, 1, 0, 0, 0, CLR,      1);

    drive(0, 16'h0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("reset_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("reset_out_data",  {16'd0, a_out_data}, {16'd0, CLR});
    check("reset_in_ready",  {31'd0, a_in_ready}, 32'd1);
    check("reset_bubble",    {16'd0, a_bubble}, 32'd0);

    @(negedge clk);
    reset = 1'b0;

    bub = 0;
    prev_ov = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].st, tbl[i].fl);
      step();
      if (!prev_ov) bub++;
      prev_ov = tbl[i].eov;
      check($sformatf("vec%0d_out_valid", i), {31'd0, a_out_valid}, {31'd0, tbl[i].eov});
      check($sformatf("vec%0d_out_data", i),  {16'd0, a_out_data},  {16'd0, tbl[i].eod});
      check($sformatf("vec%0d_in_ready", i),  {31'd0, a_in_ready},  {31'd0, tbl[i].eir});
      check($sformatf("vec%0d_bubble", i),    {16'd0, a_bubble},    bub);
    end

    // Stall beats flush: DEAD held, flush forgotten, later plain flush empties
    drive(0, 16'h0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1, 16'hDEAD, 0, 0, 0);
    step();
    check("p0_load_valid", {31'd0, b_out_valid}, 32'd1);
    check("p0_load_data",  {16'd0, b_out_data}, 32'h0000DEAD);
    drive(0, 16'h0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("p0_hold%0d_valid", i), {31'd0, b_out_valid}, 32'd1);
      check($sformatf("p0_hold%0d_data", i),  {16'd0, b_out_data}, 32'h0000DEAD);
      check($sformatf("p1_flushed%0d_valid", i), {31'd0, a_out_valid}, 32'd0);
    end
    drive(0, 16'h0, 0, 0, 0);
    step();
    check("p0_dropped_valid", {31'd0, b_out_valid}, 32'd1);
    check("p0_dropped_data",  {16'd0, b_out_data}, 32'h0000DEAD);
    drive(0, 16'h0, 0, 0, 1);
    step();
    check("p0_flush_valid", {31'd0, b_out_valid}, 32'd0);
    check("p0_flush_data",  {16'd0, b_out_data}, {16'd0, CLR});
    check("p0_flush_ready", {31'd0, b_in_ready}, 32'd1);

    // Async reset mid-transfer with the stage full
    drive(1, 16'h0001, 0, 0, 0);
    step();
    drive(1, 16'h0002, 0, 0, 0);
    step();
    check("full_in_ready", {31'd0, a_in_ready}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("midrst_out_data",  {16'd0, a_out_data}, {16'd0, CLR});
    check("midrst_in_ready",  {31'd0, a_in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 16'h0099, 0, 0, 0);
    step();
    check("post_rst_accept_valid", {31'd0, a_out_valid}, 32'd1);
    check("post_rst_accept_data",  {16'd0, a_out_data}, 32'h00000099);

    // Bubble saturation on the 4-bit counter
    drive(0, 16'h0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("sat_cycle%0d", i), {28'd0, c_bubble}, (i < 15) ? i : 15);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("sat_async_reset", {28'd0, c_bubble}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
